// File: rtl/router_pkg.sv
// Shared router types and header field positions.
// Header byte layout: [7:2] payload length, [1:0] destination port.
package router_pkg;

  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;
  localparam int HDR_ADDR_W  = 2;
  localparam int MAX_PAYLOAD = 63;

  typedef enum logic [2:0] {IDLE, WAIT, HREQ, HCAP, BODY} rx_state_t;

  typedef logic [HDR_LEN_MSB-HDR_LEN_LSB:0] len_t;
  // Sized to hold the largest body: MAX_PAYLOAD payload bytes plus the parity byte.
  typedef logic [$clog2(MAX_PAYLOAD+2)-1:0] cnt_t;

endpackage

// File: rtl/router_pkt_receiver_if.sv
// FIFO read-side bundle between one router output FIFO (master) and its receiver (slave).
interface router_pkt_receiver_if;
  logic       vld_out;
  logic [7:0] fifo_data;
  logic       fifo_soft_rst;
  logic       read_enb;

  modport master (output vld_out, output fifo_data, output fifo_soft_rst, input read_enb);
  modport slave  (input vld_out, input fifo_data, input fifo_soft_rst, output read_enb);
endinterface

// File: rtl/router_rx_stats.sv
// Saturating packet and error counters for one receiver port.
module router_rx_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             done,
  input  logic             err,
  input  logic             abort,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count
);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (done && (pkt_count != '1))
        pkt_count <= pkt_count + 1'b1;
      if ((err || abort) && (err_count != '1))
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: rtl/router_pkt_receiver.sv
// Drains one router output FIFO, parsing header/payload/parity into a tagged byte stream.
// FIFO data arrives one cycle after each read; the byte is registered out the cycle after that.
module router_pkt_receiver
  import router_pkg::*;
#(
  parameter logic [HDR_ADDR_W-1:0] PORT_ID     = 2'd0,
  parameter int                    START_DELAY = 0,
  parameter int                    CNT_W       = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  router_pkt_receiver_if.slave fifo,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic                 pkt_done,
  output logic                 parity_err,
  output logic                 addr_err,
  output logic                 pkt_abort,
  output len_t                 pkt_len,
  output logic [CNT_W-1:0]     pkt_count,
  output logic [CNT_W-1:0]     err_count
);

  localparam logic [4:0] WAIT_LAST = 5'((START_DELAY > 0) ? START_DELAY - 1 : 0);

  rx_state_t             state;
  logic [4:0]            wcnt;
  logic                  rd_pend;
  logic [HDR_ADDR_W-1:0] addr;
  logic [7:0]            parity;
  cnt_t                  remaining;
  cnt_t                  issued;
  cnt_t                  rcvd;

  logic rd_req;
  logic abort_ev;
  logic last_ev;
  logic par_bad;
  logic adr_bad;

  always_comb begin
    rd_req = 1'b0;
    case (state)
      HREQ:    rd_req = 1'b1;
      BODY:    rd_req = (issued < remaining);
      default: rd_req = 1'b0;
    endcase
    abort_ev = fifo.fifo_soft_rst && (state != IDLE);
    last_ev  = (state == BODY) && rd_pend && ((rcvd + cnt_t'(1)) == remaining) && !abort_ev;
    par_bad  = (fifo.fifo_data != parity);
    adr_bad  = (addr != PORT_ID);
  end

  // A flush kills the request in the same cycle so no byte is popped from the emptied FIFO.
  assign fifo.read_enb = rd_req && fifo.vld_out && !abort_ev;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      wcnt       <= '0;
      rd_pend    <= 1'b0;
      addr       <= '0;
      parity     <= '0;
      remaining  <= '0;
      issued     <= '0;
      rcvd       <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      pkt_abort  <= 1'b0;
      pkt_len    <= '0;
    end else begin
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      pkt_abort  <= 1'b0;
      rd_pend    <= fifo.read_enb;
      if (abort_ev) begin
        state     <= IDLE;
        pkt_abort <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            wcnt <= '0;
            if (fifo.vld_out)
              state <= (START_DELAY > 0) ? WAIT : HREQ;
          end
          WAIT: begin
            if (wcnt == WAIT_LAST)
              state <= HREQ;
            else
              wcnt <= wcnt + 1'b1;
          end
          HREQ: begin
            if (fifo.read_enb)
              state <= HCAP;
          end
          HCAP: begin
            out_valid <= 1'b1;
            out_sop   <= 1'b1;
            out_data  <= fifo.fifo_data;
            pkt_len   <= fifo.fifo_data[HDR_LEN_MSB:HDR_LEN_LSB];
            addr      <= fifo.fifo_data[HDR_ADDR_W-1:0];
            parity    <= fifo.fifo_data;
            remaining <= cnt_t'(fifo.fifo_data[HDR_LEN_MSB:HDR_LEN_LSB]) + cnt_t'(1);
            issued    <= '0;
            rcvd      <= '0;
            state     <= BODY;
          end
          BODY: begin
            if (fifo.read_enb)
              issued <= issued + cnt_t'(1);
            if (rd_pend) begin
              out_valid <= 1'b1;
              out_data  <= fifo.fifo_data;
              rcvd      <= rcvd + cnt_t'(1);
              if (last_ev) begin
                out_eop    <= 1'b1;
                pkt_done   <= 1'b1;
                parity_err <= par_bad;
                addr_err   <= adr_bad;
                state      <= IDLE;
              end else begin
                parity <= parity ^ fifo.fifo_data;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  router_rx_stats #(.CNT_W(CNT_W)) u_stats (
    .clock     (clock),
    .resetn    (resetn),
    .done      (last_ev),
    .err       (last_ev && (par_bad || adr_bad)),
    .abort     (abort_ev),
    .pkt_count (pkt_count),
    .err_count (err_count)
  );

endmodule

// File: tb/tb_router_pkt_receiver.sv
// Bench for router_pkt_receiver: FIFO model, byte/result scoreboard, vector table and corner sequences.
module tb_router_pkt_receiver;
  import router_pkg::*;

  logic clock;
  logic resetn;

  router_pkt_receiver_if rif();
  router_pkt_receiver_if rif2();

  logic [7:0]  out_data, out_data2;
  logic        out_valid, out_sop, out_eop, pkt_done, parity_err, addr_err, pkt_abort;
  logic        out_valid2, out_sop2, out_eop2, pkt_done2, parity_err2, addr_err2, pkt_abort2;
  len_t        pkt_len, pkt_len2;
  logic [15:0] pkt_count, err_count, pkt_count2, err_count2;

  router_pkt_receiver #(.PORT_ID(2'd0), .START_DELAY(0), .CNT_W(16)) dut (
    .clock(clock), .resetn(resetn), .fifo(rif),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .pkt_done(pkt_done), .parity_err(parity_err), .addr_err(addr_err), .pkt_abort(pkt_abort),
    .pkt_len(pkt_len), .pkt_count(pkt_count), .err_count(err_count)
  );

  router_pkt_receiver #(.PORT_ID(2'd1), .START_DELAY(5), .CNT_W(16)) dut2 (
    .clock(clock), .resetn(resetn), .fifo(rif2),
    .out_data(out_data2), .out_valid(out_valid2), .out_sop(out_sop2), .out_eop(out_eop2),
    .pkt_done(pkt_done2), .parity_err(parity_err2), .addr_err(addr_err2), .pkt_abort(pkt_abort2),
    .pkt_len(pkt_len2), .pkt_count(pkt_count2), .err_count(err_count2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // FIFO model: one-cycle read latency, flushed by reset or soft reset.
  logic [7:0] mem [256];
  int         wr_ptr;
  int         rd_ptr;
  logic [7:0] fdat;
  bit         hold;
  logic       vld2;

  assign rif.vld_out    = (rd_ptr != wr_ptr) && !hold;
  assign rif.fifo_data  = fdat;
  assign rif2.vld_out   = vld2;
  assign rif2.fifo_data = 8'h00;
  assign rif2.fifo_soft_rst = 1'b0;

  always @(posedge clock) begin
    if (!resetn || rif.fifo_soft_rst)
      rd_ptr <= wr_ptr;
    else if (rif.read_enb && rif.vld_out) begin
      fdat   <= mem[rd_ptr % 256];
      rd_ptr <= rd_ptr + 1;
    end
  end

  typedef struct packed {logic sop; logic eop; logic [7:0] data;} exp_t;
  typedef struct packed {logic perr; logic aerr;} res_t;
  typedef struct {logic [7:0] hdr; logic [7:0] step; bit bad_par; bit perr; bit aerr;} vec_t;

  exp_t exp_q[$];
  res_t res_q[$];
  vec_t vecs[6];
  int   n_checks, n_pass, n_abort_seen, exp_pkts, exp_errs;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  task automatic bad(input string nm, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got %0h, expected nothing", nm, act);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 256] = b;
    wr_ptr++;
  endtask

  // Loads a whole packet into the FIFO; only the first 'keep' bytes are expected at the output.
  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] step, input bit bad_par,
                          input bit perr, input bit aerr, input int keep);
    int         len;
    logic [7:0] par;
    logic [7:0] b;
    len = int'(hdr[7:2]);
    par = hdr;
    push(hdr);
    if (keep > 0) exp_q.push_back('{1'b1, 1'b0, hdr});
    for (int i = 0; i < len; i++) begin
      b = 8'(step * (i + 1));
      par = par ^ b;
      push(b);
      if (i + 1 < keep) exp_q.push_back('{1'b0, 1'b0, b});
    end
    b = bad_par ? 8'hFF : par;
    push(b);
    if (len + 1 < keep) begin
      exp_q.push_back('{1'b0, 1'b1, b});
      res_q.push_back('{perr, aerr});
      exp_pkts++;
      if (perr || aerr) exp_errs++;
    end
  endtask

  task automatic mon_sample();
    exp_t e;
    res_t r;
    if (out_valid) begin
      if (exp_q.size() == 0) bad("unexpected_byte", out_data);
      else begin
        e = exp_q.pop_front();
        chk("byte_data", out_data, e.data);
        chk("byte_sop", out_sop, e.sop);
        chk("byte_eop", out_eop, e.eop);
        chk("byte_done", pkt_done, e.eop);
        if (e.eop) begin
          if (res_q.size() == 0) bad("unexpected_result", pkt_done);
          else begin
            r = res_q.pop_front();
            chk("parity_err", parity_err, r.perr);
            chk("addr_err", addr_err, r.aerr);
          end
        end
      end
    end else if (pkt_done || out_sop || out_eop) begin
      bad("flag_without_valid", {pkt_done, out_sop, out_eop});
    end
    if (pkt_abort) n_abort_seen++;
  endtask

  task automatic wait_drain(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clock);
      #2;
      done = (exp_q.size() == 0) && (res_q.size() == 0);
    end
    if (!done) bad({nm, "_timeout"}, exp_q.size());
    @(negedge clock);
  endtask

  task automatic wait_bytes(input int n, input string nm);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 200 && cnt < n; i++) begin
      @(negedge clock);
      if (out_valid) cnt++;
    end
    if (cnt < n) bad({nm, "_timeout"}, cnt);
  endtask

  initial begin
    logic [8:0] tr;
    int         cyc;
    resetn = 1'b0;
    rif.fifo_soft_rst = 1'b0;
    hold = 1'b0;
    vld2 = 1'b0;
    vecs[0] = '{8'h0C, 8'h11, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h0C, 8'h11, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'hFC, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h16, 8'h07, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h17, 8'h05, 1'b1, 1'b1, 1'b1};
    fork
      forever begin
        @(negedge clock);
        mon_sample();
      end
    join_none

    repeat (3) @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags", {out_sop, out_eop, pkt_done, parity_err, addr_err, pkt_abort}, 0);
    chk("rst_pkt_len", pkt_len, 0);
    chk("rst_counts", {pkt_count, err_count}, 0);
    chk("rst_read_enb", rif.read_enb, 0);
    resetn = 1'b1;
    @(negedge clock);

    // First read of the delayed instance lands START_DELAY+1 cycles after vld_out rises.
    vld2 = 1'b1;
    cyc = 0;
    for (int i = 0; i < 20 && !rif2.read_enb; i++) begin
      @(negedge clock);
      cyc++;
    end
    chk("start_delay5_cycles", cyc, 6);
    vld2 = 1'b0;
    @(negedge clock);

    // Read strobe shape: header read, one bubble, four body reads.
    send_pkt(8'h0C, 8'h11, 1'b0, 1'b0, 1'b0, 1000);
    tr = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      tr = {tr[7:0], rif.read_enb};
    end
    chk("read_enb_pattern", tr, 9'b101111000);
    wait_drain("pkt1");
    chk("pkt1_count", pkt_count, 1);

    for (int v = 0; v < 6; v++) begin
      send_pkt(vecs[v].hdr, vecs[v].step, vecs[v].bad_par, vecs[v].perr, vecs[v].aerr, 1000);
      wait_drain("vec");
      chk("vec_pkt_count", pkt_count, exp_pkts);
      chk("vec_err_count", err_count, exp_errs);
      chk("vec_pkt_len", pkt_len, vecs[v].hdr[7:2]);
    end

    // vld_out withdrawn for three cycles mid-body.
    send_pkt(8'h14, 8'h21, 1'b0, 1'b0, 1'b0, 1000);
    wait_bytes(3, "stall");
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stall_read_enb", rif.read_enb, 0);
    end
    hold = 1'b0;
    wait_drain("stall");
    chk("stall_counts", {pkt_count, err_count}, {16'(exp_pkts), 16'(exp_errs)});

    // Soft reset after header plus two payload bytes.
    n_abort_seen = 0;
    send_pkt(8'h28, 8'h09, 1'b0, 1'b0, 1'b0, 3);
    wait_bytes(3, "abort");
    rif.fifo_soft_rst = 1'b1;
    @(negedge clock);
    rif.fifo_soft_rst = 1'b0;
    chk("abort_pulse", pkt_abort, 1);
    chk("abort_inflight_dropped", out_valid, 0);
    chk("abort_no_done", pkt_done, 0);
    exp_errs++;
    @(negedge clock);
    chk("abort_one_cycle", pkt_abort, 0);
    chk("abort_counts", {pkt_count, err_count}, {16'(exp_pkts), 16'(exp_errs)});
    send_pkt(8'h0C, 8'h11, 1'b0, 1'b0, 1'b0, 1000);
    wait_drain("after_abort");
    chk("after_abort_counts", {pkt_count, err_count}, {16'(exp_pkts), 16'(exp_errs)});
    chk("abort_seen", n_abort_seen, 1);

    // Hard reset mid-body clears everything without an abort pulse.
    send_pkt(8'h28, 8'h0B, 1'b0, 1'b0, 1'b0, 3);
    wait_bytes(3, "midrst");
    resetn = 1'b0;
    @(negedge clock);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_flags", {out_sop, out_eop, pkt_done, parity_err, addr_err, pkt_abort}, 0);
    chk("midrst_data_len", {out_data, 2'b00, pkt_len}, 0);
    chk("midrst_counts", {pkt_count, err_count}, 0);
    chk("midrst_read_enb", rif.read_enb, 0);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    chk("midrst_quiet", {out_valid, pkt_abort, pkt_done}, 0);
    chk("midrst_sb_empty", exp_q.size() + res_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
